// File: rtl/cam_pkg.sv
// Shared types and default geometry for the frame capture controller.
package cam_pkg;
  localparam int H_PIXELS_DEF = 160;
  localparam int V_LINES_DEF  = 120;
  localparam int ADDR_W_DEF   = 15;
  localparam int FRAME_WORDS  = H_PIXELS_DEF * V_LINES_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int frame_words(input int h, input int v);
    return h * v;
  endfunction
endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Frame RAM port plus image-processing read client, seen from the controller.
interface frame_capture_ctrl_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              i_Rd_Req;
  logic [ADDR_W-1:0] i_Rd_Addr;
  logic              o_Rd_Grant;
  logic [7:0]        o_Rd_Data;
  logic              o_Rd_Valid;
  logic [ADDR_W-1:0] o_RAM_Addr;
  logic [7:0]        o_RAM_Din;
  logic              o_RAM_WE;
  logic [7:0]        i_RAM_Dout;

  modport master (
    input  i_Rd_Req, i_Rd_Addr, i_RAM_Dout,
    output o_Rd_Grant, o_Rd_Data, o_Rd_Valid, o_RAM_Addr, o_RAM_Din, o_RAM_WE
  );

  modport slave (
    output i_Rd_Req, i_Rd_Addr, i_RAM_Dout,
    input  o_Rd_Grant, o_Rd_Data, o_Rd_Valid, o_RAM_Addr, o_RAM_Din, o_RAM_WE
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses (3 cycles pin-to-pulse).
module sync_edge (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Rise,
  output logic o_Fall
);
  logic r_s1, r_s2, r_s3, r_rise, r_fall;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_Async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_Rise = r_rise;
  assign o_Fall = r_fall;
endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame capture sequencer and frame-RAM arbiter between the camera
// write path and an image-processing read client.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_PIXELS    = H_PIXELS_DEF,
  parameter int V_LINES     = V_LINES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ARM_TIMEOUT = 2_000_000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Capture_Req,
  input  logic              i_VS,
  input  logic              i_HS,
  output logic              o_EnableCameraRead,
  input  logic [ADDR_W-1:0] i_Cam_Addr,
  input  logic [7:0]        i_Cam_Data,
  input  logic              i_Cam_WE,
  frame_capture_ctrl_if.master bus,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_Size_Error,
  output logic              o_Timeout
);
  localparam int PIX_W  = ADDR_W + 1;
  localparam int LINE_W = $clog2(V_LINES) + 1;
  localparam int TMO_W  = $clog2(ARM_TIMEOUT + 1);
  localparam logic [PIX_W-1:0]  FRAME_CNT = PIX_W'(frame_words(H_PIXELS, V_LINES));
  localparam logic [LINE_W-1:0] LINE_CNT  = LINE_W'(V_LINES);
  localparam logic [TMO_W-1:0]  TMO_CNT   = TMO_W'(ARM_TIMEOUT);

  state_t r_state, w_next;
  logic   w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
  logic   w_cam_own, w_grant, w_arm, w_tmo_hit, w_in_range, w_cam_ok, w_cam_ovf;
  logic   r_drain, r_in_line, r_ram_we, r_frame_done, r_size_err, r_timeout;
  logic [1:0]        r_rd_vld_pipe;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;

  sync_edge u_vs_sync (.i_Clk, .i_Reset, .i_Async(i_VS), .o_Rise(w_vs_rise), .o_Fall(w_vs_fall));
  sync_edge u_hs_sync (.i_Clk, .i_Reset, .i_Async(i_HS), .o_Rise(w_hs_rise), .o_Fall(w_hs_fall));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_Capture_Req) w_next = ST_ARMED;
      ST_ARMED:   if (w_tmo_hit) w_next = ST_IDLE;
                  else if (w_vs_fall) w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_vs_rise) w_next = ST_DRAIN;
      ST_DRAIN:   if (r_drain) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Camera keeps the RAM through DRAIN so writes already in its pipe land.
  always_comb begin
    o_Busy             = (r_state != ST_IDLE);
    o_EnableCameraRead = (r_state == ST_CAPTURE);
    w_cam_own          = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
    w_grant            = bus.i_Rd_Req && (r_state == ST_IDLE);
    w_arm              = i_Capture_Req && (r_state == ST_IDLE);
    w_tmo_hit          = (r_tmo_cnt == TMO_CNT);
    w_in_range         = ({1'b0, i_Cam_Addr} < FRAME_CNT);
    w_cam_ok           = w_cam_own && i_Cam_WE && w_in_range;
    w_cam_ovf          = w_cam_own && i_Cam_WE && !w_in_range;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_rd_vld_pipe <= '0;
      r_frame_done  <= 1'b0;
      r_drain       <= 1'b0;
      r_tmo_cnt     <= '0;
      r_size_err    <= 1'b0;
      r_timeout     <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_in_line     <= 1'b0;
    end else begin
      r_ram_we <= w_cam_ok;
      if (w_cam_own) begin
        r_ram_addr <= i_Cam_Addr;
        r_ram_din  <= i_Cam_Data;
      end else if (w_grant) begin
        r_ram_addr <= bus.i_Rd_Addr;
      end
      r_rd_vld_pipe <= {r_rd_vld_pipe[0], w_grant};
      r_frame_done  <= (r_state == ST_DONE);
      r_drain       <= (r_state == ST_DRAIN) && !r_drain;
      r_tmo_cnt     <= (r_state == ST_ARMED) ? r_tmo_cnt + 1'b1 : '0;

      if (w_arm) begin
        r_size_err <= 1'b0;
        r_timeout  <= 1'b0;
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_in_line  <= 1'b0;
      end else begin
        if ((r_state == ST_ARMED) && w_tmo_hit) r_timeout <= 1'b1;
        if (w_cam_ovf) r_size_err <= 1'b1;
        if ((r_state == ST_DONE) && ((r_pix_cnt != FRAME_CNT) || (r_line_cnt != LINE_CNT)))
          r_size_err <= 1'b1;
        if (w_cam_ok && (r_pix_cnt != '1)) r_pix_cnt <= r_pix_cnt + 1'b1;
        // A line counts only if its HREF rise was seen inside the capture window.
        if (w_cam_own) begin
          if (w_hs_rise) begin
            r_in_line <= 1'b1;
          end else if (w_hs_fall) begin
            r_in_line <= 1'b0;
            if (r_in_line && (r_line_cnt != '1)) r_line_cnt <= r_line_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_Rd_Grant = w_grant;
  assign bus.o_Rd_Data  = bus.i_RAM_Dout;
  assign bus.o_Rd_Valid = r_rd_vld_pipe[1];
  assign bus.o_RAM_Addr = r_ram_addr;
  assign bus.o_RAM_Din  = r_ram_din;
  assign bus.o_RAM_WE   = r_ram_we;
  assign o_Frame_Done   = r_frame_done;
  assign o_Size_Error   = r_size_err;
  assign o_Timeout      = r_timeout;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a behavioural 1-cycle frame RAM.
module tb_frame_capture_ctrl;
  localparam int H = 160, V = 120, AW = 15, TMO = 100, FRAME = H * V;

  logic clk = 1'b0, rst = 1'b1, req = 1'b0, vs = 1'b1, hs = 1'b0, cam_we = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [7:0]    cam_data = '0;
  logic en, busy, done, serr, tmo;
  int checks = 0, failures = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [7:0] mem [0:(1<<AW)-1];

  frame_capture_ctrl_if #(.ADDR_W(AW)) bus ();

  frame_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .ARM_TIMEOUT(TMO)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Capture_Req(req), .i_VS(vs), .i_HS(hs),
    .o_EnableCameraRead(en), .i_Cam_Addr(cam_addr), .i_Cam_Data(cam_data), .i_Cam_WE(cam_we),
    .bus(bus), .o_Busy(busy), .o_Frame_Done(done), .o_Size_Error(serr), .o_Timeout(tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_RAM_WE) begin
      mem[bus.o_RAM_Addr] <= bus.o_RAM_Din;
      wr_cnt <= wr_cnt + 1;
    end
    bus.i_RAM_Dout <= mem[bus.o_RAM_Addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [7:0] pix(input int p);
    return 8'((p * 7 + 3) & 255);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic arm();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (en !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (en !== 1'b1) begin failures++; $display("FAIL %s_enable_wait got=%b exp=1", tag, en); end
  endtask

  task automatic drive_lines(input int nlines);
    int p = 0;
    for (int l = 0; l < nlines; l++) begin
      hs = 1'b1;
      for (int x = 0; x < H; x++) begin
        cam_we = 1'b1; cam_addr = AW'(p); cam_data = pix(p); p++;
        step();
      end
      cam_we = 1'b0; hs = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, en, done, serr, tmo, bus.o_RAM_WE, bus.o_Rd_Valid} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000000",
                           {busy, en, done, serr, tmo, bus.o_RAM_WE, bus.o_Rd_Valid});
    end
    checks++;
    if (bus.o_RAM_Addr !== 15'd0 || bus.o_RAM_Din !== 8'd0) begin
      failures++; $display("FAIL reset_ram_port got=%h/%h exp=0/0", bus.o_RAM_Addr, bus.o_RAM_Din);
    end
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_full_frame();
    int w0 = wr_cnt, d0 = done_cnt;
    arm();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_armed_busy got=%b exp=1", busy); end
    repeat (2) step();
    vs = 1'b0;
    repeat (3) step();
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL vsfall_lat3 got=%b exp=0", en); end
    step();
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL vsfall_lat4 got=%b exp=1", en); end
    drive_lines(V);
    vs = 1'b1;
    repeat (3) step();
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL vsrise_lat3 got=%b exp=1", en); end
    step();
    checks++;
    if (en !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL drain_entry got=en%b busy%b exp=en0 busy1", en, busy);
    end
    repeat (2) step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || serr !== 1'b0) begin
      failures++; $display("FAIL full_done got=done%b busy%b serr%b exp=done1 busy0 serr0", done, busy, serr);
    end
    step();
    checks++;
    if (wr_cnt - w0 != FRAME) begin failures++; $display("FAIL full_writes got=%0d exp=%0d", wr_cnt - w0, FRAME); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reads();
    bus.i_Rd_Req = 1'b1; bus.i_Rd_Addr = 15'd0;
    #1;
    checks++; if (bus.o_Rd_Grant !== 1'b1) begin failures++; $display("FAIL rd_grant_idle got=%b exp=1", bus.o_Rd_Grant); end
    step();
    checks++;
    if (bus.o_RAM_Addr !== 15'd0 || bus.o_Rd_Valid !== 1'b0) begin
      failures++; $display("FAIL rd_n1 got=addr%0d vld%b exp=addr0 vld0", bus.o_RAM_Addr, bus.o_Rd_Valid);
    end
    bus.i_Rd_Addr = 15'd1;
    step();
    checks++;
    if (bus.o_Rd_Valid !== 1'b1 || bus.o_Rd_Data !== 8'd3) begin
      failures++; $display("FAIL rd_n2 got=vld%b data%0d exp=vld1 data3", bus.o_Rd_Valid, bus.o_Rd_Data);
    end
    bus.i_Rd_Addr = 15'd2;
    step();
    bus.i_Rd_Req = 1'b0;
    checks++;
    if (bus.o_Rd_Valid !== 1'b1 || bus.o_Rd_Data !== 8'd10) begin
      failures++; $display("FAIL rd_n3 got=vld%b data%0d exp=vld1 data10", bus.o_Rd_Valid, bus.o_Rd_Data);
    end
    step();
    checks++;
    if (bus.o_Rd_Valid !== 1'b1 || bus.o_Rd_Data !== 8'd17) begin
      failures++; $display("FAIL rd_n4 got=vld%b data%0d exp=vld1 data17", bus.o_Rd_Valid, bus.o_Rd_Data);
    end
    step();
    checks++; if (bus.o_Rd_Valid !== 1'b0) begin failures++; $display("FAIL rd_n5 got=%b exp=0", bus.o_Rd_Valid); end
  endtask

  task automatic test_short_frame();
    arm();
    vs = 1'b0;
    wait_en("short");
    drive_lines(V - 1);
    bus.i_Rd_Req = 1'b1; bus.i_Rd_Addr = 15'd1;
    #1;
    checks++; if (bus.o_Rd_Grant !== 1'b0) begin failures++; $display("FAIL rd_stall_capture got=%b exp=0", bus.o_Rd_Grant); end
    vs = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (bus.o_Rd_Grant !== 1'b0) begin failures++; $display("FAIL rd_stall_c%0d got=%b exp=0", i, bus.o_Rd_Grant); end
    end
    step();
    checks++;
    if (bus.o_Rd_Grant !== 1'b1 || done !== 1'b1 || serr !== 1'b1) begin
      failures++; $display("FAIL short_done got=gnt%b done%b serr%b exp=gnt1 done1 serr1", bus.o_Rd_Grant, done, serr);
    end
    bus.i_Rd_Req = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    arm();
    checks++; if (serr !== 1'b0) begin failures++; $display("FAIL serr_clear_on_req got=%b exp=0", serr); end
    vs = 1'b0;
    wait_en("ovf");
    cam_we = 1'b1; cam_addr = 15'd19200; cam_data = 8'hAA;
    step();
    cam_addr = 15'd5; cam_data = 8'h5A;
    checks++; if (bus.o_RAM_WE !== 1'b0) begin failures++; $display("FAIL ovf_we got=%b exp=0", bus.o_RAM_WE); end
    checks++; if (serr !== 1'b1) begin failures++; $display("FAIL ovf_serr got=%b exp=1", serr); end
    step();
    cam_we = 1'b0;
    checks++;
    if (bus.o_RAM_WE !== 1'b1 || bus.o_RAM_Addr !== 15'd5 || bus.o_RAM_Din !== 8'h5A) begin
      failures++; $display("FAIL cam_write_reg got=we%b addr%0d din%h exp=we1 addr5 din5a",
                           bus.o_RAM_WE, bus.o_RAM_Addr, bus.o_RAM_Din);
    end
    vs = 1'b1;
    repeat (7) step();
    checks++;
    if (done !== 1'b1 || serr !== 1'b1) begin
      failures++; $display("FAIL ovf_done got=done%b serr%b exp=done1 serr1", done, serr);
    end
    step();
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    arm();
    repeat (100) step();
    checks++;
    if (busy !== 1'b1 || tmo !== 1'b0) begin
      failures++; $display("FAIL tmo_c100 got=busy%b tmo%b exp=busy1 tmo0", busy, tmo);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tmo !== 1'b1) begin
      failures++; $display("FAIL tmo_c101 got=busy%b tmo%b exp=busy0 tmo1", busy, tmo);
    end
    repeat (2) step();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL tmo_no_done got=%0d exp=%0d", done_cnt, d0); end
  endtask

  task automatic test_reset_mid();
    arm();
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL tmo_clear_on_req got=%b exp=0", tmo); end
    vs = 1'b0;
    wait_en("rstmid");
    cam_we = 1'b1; cam_addr = 15'd7; cam_data = 8'h11;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (en !== 1'b0 || bus.o_RAM_WE !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=en%b we%b busy%b exp=000", en, bus.o_RAM_WE, busy);
    end
    rst = 1'b0; cam_we = 1'b0; vs = 1'b1;
    repeat (4) step();
    bus.i_Rd_Req = 1'b1; bus.i_Rd_Addr = 15'd0;
    step();
    bus.i_Rd_Req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.o_Rd_Valid !== 1'b0) begin failures++; $display("FAIL rd_squash got=%b exp=0", bus.o_Rd_Valid); end
    step();
  endtask

  initial begin
    bus.i_Rd_Req = 1'b0;
    bus.i_Rd_Addr = '0;
    test_reset();
    test_full_frame();
    test_reads();
    test_short_frame();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
